// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin requester slice: default sizes, payload type and log2 helper.
package rr_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 4;

  typedef logic [DefWidth-1:0] payload_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned log2ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_req_fifo.sv
// Payload FIFO for the requester: storage, wrapping pointers, entry count, full/empty flags.
module rr_req_fifo
  import rr_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth,
  localparam int unsigned PtrW = log2ceil(Depth),
  localparam int unsigned LevelW = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o,
  output logic [Width-1:0]  rd_data_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              push_ok, pop_ok;

  always_comb begin
    full_o   = (level_q == LevelW'(Depth));
    empty_o  = (level_q == '0);
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop_ok) level_d = level_q + LevelW'(1);
    if (!push_ok && pop_ok) level_d = level_q - LevelW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Storage is never cleared, so mask stale contents while empty.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/rr_requester.sv
// Arbiter client request initiator: buffers payloads and holds req/req_data until ack.
// Optional ack timeout enabled by defining REQ_TIMEOUT_EN.
module rr_requester
  import rr_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     req,
  output logic [WIDTH-1:0]         req_data,
  input  logic                     ack,
  output logic [log2ceil(DEPTH):0] level,
  output logic                     overflow,
  output logic                     timeout
);

  logic empty;
  logic pop;
  logic abandon;
  logic overflow_q, overflow_d;

  rr_req_fifo #(
    .Width(WIDTH),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .rd_data_o  (req_data)
  );

  assign req = !empty;
  assign pop = req && (ack || abandon);

  always_comb begin
    overflow_d = overflow_q | (push & full);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef REQ_TIMEOUT_EN
  localparam int unsigned CntW = log2ceil(TIMEOUT);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;

  // Counter holds TIMEOUT-1 during the last permitted unacked cycle; ack wins on that edge.
  always_comb begin
    abandon    = req && !ack && (wait_cnt_q == CntW'(TIMEOUT - 1));
    timeout_d  = abandon;
    wait_cnt_d = wait_cnt_q + CntW'(1);
    if (!req || ack || abandon) wait_cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign abandon = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_requester.sv
// Directed self-checking bench for rr_requester (WIDTH=8, DEPTH=4, TIMEOUT=16).
module tb_rr_requester;

  logic       clock;
  logic       reset;
  logic       push;
  logic [7:0] push_data;
  logic       full;
  logic       req;
  logic [7:0] req_data;
  logic       ack;
  logic [2:0] level;
  logic       overflow;
  logic       timeout;

  int tests_run;
  int tests_failed;

  rr_requester #(
    .WIDTH  (8),
    .DEPTH  (4),
    .TIMEOUT(16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .full     (full),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .level    (level),
    .overflow (overflow),
    .timeout  (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b0;
    push      = 1'b0;
    push_data = 8'h00;
    ack       = 1'b0;

    // Reset state
    #3;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_req_data", 32'(req_data), 32'h00);
    #9;
    reset = 1'b1;
    tick();

    // Idle with random ack: nothing happens
    for (int i = 0; i < 8; i++) begin
      ack = 1'($urandom_range(0, 1));
      tick();
      chk("idle_req", 32'(req), 32'd0);
      chk("idle_level", 32'(level), 32'd0);
    end
    ack = 1'b0;

    // Single push, hold without ack, then transfer
    push = 1'b1;
    push_data = 8'hA5;
    tick();
    push = 1'b0;
    chk("a5_req_rise", 32'(req), 32'd1);
    chk("a5_level", 32'(level), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("a5_hold_data", 32'(req_data), 32'hA5);
      chk("a5_hold_req", 32'(req), 32'd1);
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("a5_req_fall", 32'(req), 32'd0);
    chk("a5_level_end", 32'(level), 32'd0);

    // Fill to DEPTH, then overflow
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1;
      push_data = 8'(i);
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    push_data = 8'h05;
    tick();
    push = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_head", 32'(req_data), 32'h01);

    // Back-to-back drain with ack held high
    ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_req", 32'(req), 32'd1);
      chk("drain_data", 32'(req_data), 32'(i));
      tick();
    end
    ack = 1'b0;
    chk("drain_req_end", 32'(req), 32'd0);
    chk("drain_level_end", 32'(level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and transfer at level 2
    push = 1'b1;
    push_data = 8'h10;
    tick();
    push_data = 8'h20;
    tick();
    chk("sim_level_pre", 32'(level), 32'd2);
    push_data = 8'h77;
    ack = 1'b1;
    tick();
    push = 1'b0;
    ack = 1'b0;
    chk("sim_level", 32'(level), 32'd2);
    chk("sim_head", 32'(req_data), 32'h20);
    ack = 1'b1;
    tick();
    chk("sim_order", 32'(req_data), 32'h77);
    tick();
    ack = 1'b0;
    chk("sim_level_end", 32'(level), 32'd0);

    // Full FIFO: push with transfer is rejected
    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      push_data = 8'hB1 + 8'(i);
      tick();
    end
    push_data = 8'hC5;
    ack = 1'b1;
    tick();
    push = 1'b0;
    ack = 1'b0;
    chk("fullpop_level", 32'(level), 32'd3);
    chk("fullpop_head", 32'(req_data), 32'hB2);
    chk("fullpop_req", 32'(req), 32'd1);

    // Asynchronous reset mid-request
    reset = 1'b0;
    #2;
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_data", 32'(req_data), 32'h00);
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_level", 32'(level), 32'd0);

`ifdef REQ_TIMEOUT_EN
    // Never acked: abandoned after 16 unacked cycles
    push = 1'b1;
    push_data = 8'h3C;
    tick();
    push = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_pulse", 32'(timeout), 32'd0);
      chk("to_wait_level", 32'(level), 32'd1);
      tick();
    end
    chk("to_last_data", 32'(req_data), 32'h3C);
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_level", 32'(level), 32'd0);
    chk("to_req", 32'(req), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'd0);

    // Ack on the 16th cycle takes priority
    push = 1'b1;
    push_data = 8'h3C;
    tick();
    push = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("toack_wait_pulse", 32'(timeout), 32'd0);
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("toack_level", 32'(level), 32'd0);
    chk("toack_no_pulse", 32'(timeout), 32'd0);
    tick();
    chk("toack_no_pulse2", 32'(timeout), 32'd0);
`else
    // Without timeout, req is held indefinitely
    push = 1'b1;
    push_data = 8'h3C;
    tick();
    push = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("hold_timeout", 32'(timeout), 32'd0);
      chk("hold_level", 32'(level), 32'd1);
      tick();
    end
    chk("hold_data", 32'(req_data), 32'h3C);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("hold_level_end", 32'(level), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
